// File: rtl/usart_rx_buffer_ctrl_pkg.sv
// Shared definitions for the USART receive buffer controller:
// controller state codes, UCSZ character-size codes and entry layout.
package usart_rx_buffer_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_RUN      = 2'd1,
      ST_FLUSH    = 2'd2
   } rx_state_e;

   localparam logic [2:0] UCSZ_5 = 3'd0;
   localparam logic [2:0] UCSZ_6 = 3'd1;
   localparam logic [2:0] UCSZ_7 = 3'd2;
   localparam logic [2:0] UCSZ_8 = 3'd3;
   localparam logic [2:0] UCSZ_9 = 3'd7;

   // Each stored entry is {fe, upe, data}
   localparam int unsigned ENTRY_FLAGS_W = 2;

   // Reserved UCSZ codes fall back to 8-bit characters
   function automatic int unsigned char_bits(input logic [2:0] ucsz);
      case (ucsz)
         UCSZ_5:  return 5;
         UCSZ_6:  return 6;
         UCSZ_7:  return 7;
         UCSZ_8:  return 8;
         UCSZ_9:  return 9;
         default: return 8;
      endcase
   endfunction

endpackage

// File: rtl/usart_rx_fifo.sv
// Small receive FIFO with compare-wrapped pointers and a registered head
// entry that reads as zero whenever the buffer is empty.
module usart_rx_fifo #(
   parameter int unsigned W     = 11,
   parameter int unsigned DEPTH = 2
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic                         i_flush,
   input  logic [W-1:0]                 i_wdata,
   output logic [W-1:0]                 o_head,
   output logic                         o_nempty,
   output logic [$clog2(DEPTH+1)-1:0]   o_level
);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr, r_rd, w_wr_nxt, w_rd_nxt;
   logic [LVL_W-1:0] r_level, w_level_nxt;
   logic [W-1:0]     r_head, w_head_nxt;
   logic             r_nempty, w_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Next pointers/level, and what the head register must show next cycle
   always_comb begin
      w_pop       = (i_pop || i_flush) && (r_level != '0);
      w_rd_nxt    = w_pop  ? ptr_inc(r_rd) : r_rd;
      w_wr_nxt    = i_push ? ptr_inc(r_wr) : r_wr;
      w_level_nxt = r_level;
      if (i_push && !w_pop)
         w_level_nxt = r_level + LVL_W'(1);
      else if (!i_push && w_pop)
         w_level_nxt = r_level - LVL_W'(1);
      if (w_level_nxt == '0)
         w_head_nxt = '0;
      else if (i_push && (r_wr == w_rd_nxt))
         w_head_nxt = i_wdata;
      else
         w_head_nxt = r_mem[w_rd_nxt];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr     <= '0;
         r_rd     <= '0;
         r_level  <= '0;
         r_head   <= '0;
         r_nempty <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++)
            r_mem[i] <= '0;
      end else begin
         r_wr     <= w_wr_nxt;
         r_rd     <= w_rd_nxt;
         r_level  <= w_level_nxt;
         r_head   <= w_head_nxt;
         r_nempty <= (w_level_nxt != '0);
         if (i_push)
            r_mem[r_wr] <= i_wdata;
      end
   end

   assign o_head   = r_head;
   assign o_nempty = r_nempty;
   assign o_level  = r_level;

endmodule

// File: rtl/usart_rx_buffer_ctrl.sv
// USART receive buffer controller: captures completed frames into a FIFO,
// masks to character size, tracks overrun and flushes on receiver disable.
module usart_rx_buffer_ctrl
   import usart_rx_buffer_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 9,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_rxen,
   input  logic                         i_frame_done,
   input  logic [DATA_W-1:0]            i_frame_data,
   input  logic                         i_parity_err,
   input  logic                         i_frame_err,
   input  logic [2:0]                   i_ucsz,
   input  logic                         i_rd_en,
   input  logic                         i_rxcie,
   output logic [DATA_W-1:0]            o_rx_data,
   output logic                         o_rxc,
   output logic                         o_fe,
   output logic                         o_upe,
   output logic                         o_dor,
   output logic                         o_irq,
   output logic [$clog2(DEPTH+1)-1:0]   o_level
);
   localparam int unsigned LVL_W   = $clog2(DEPTH + 1);
   localparam int unsigned ENTRY_W = DATA_W + ENTRY_FLAGS_W;

   rx_state_e          r_state, w_state_nxt;
   logic               r_dor, w_dor_nxt;
   logic               w_push, w_pop_rd, w_ovr, w_flush;
   logic [DATA_W-1:0]  w_data_m;
   logic [ENTRY_W-1:0] w_head;
   logic               w_nempty;
   logic [LVL_W-1:0]   w_level;
   int unsigned        w_nbits;

   // Controller next state, push/overrun qualification and DOR update
   always_comb begin
      w_state_nxt = r_state;
      w_dor_nxt   = r_dor;
      w_nbits     = char_bits(i_ucsz);
      w_data_m    = '0;
      w_flush     = (r_state == ST_FLUSH);
      w_pop_rd    = i_rd_en && (w_level != '0);
      w_push      = (r_state == ST_RUN) && i_frame_done &&
                    ((w_level < LVL_W'(DEPTH)) || w_pop_rd);
      w_ovr       = (r_state == ST_RUN) && i_frame_done && !w_push;

      for (int unsigned i = 0; i < DATA_W; i++)
         w_data_m[i] = i_frame_data[i] & (i < w_nbits);

      case (r_state)
         ST_DISABLED: if (i_rxen) w_state_nxt = ST_RUN;
         ST_RUN:      if (!i_rxen) w_state_nxt = (w_level != '0) ? ST_FLUSH : ST_DISABLED;
         ST_FLUSH:    if (w_level == '0) w_state_nxt = i_rxen ? ST_RUN : ST_DISABLED;
         default:     w_state_nxt = ST_DISABLED;
      endcase

      if ((r_state == ST_RUN) && (w_state_nxt == ST_FLUSH))
         w_dor_nxt = 1'b0;
      else if (w_pop_rd)
         w_dor_nxt = 1'b0;
      else if (w_ovr)
         w_dor_nxt = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_DISABLED;
         r_dor   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dor   <= w_dor_nxt;
      end
   end

   usart_rx_fifo #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_push   (w_push),
      .i_pop    (i_rd_en),
      .i_flush  (w_flush),
      .i_wdata  ({i_frame_err, i_parity_err, w_data_m}),
      .o_head   (w_head),
      .o_nempty (w_nempty),
      .o_level  (w_level)
   );

   assign o_rx_data = w_head[DATA_W-1:0];
   assign o_upe     = w_head[DATA_W];
   assign o_fe      = w_head[DATA_W+1];
   assign o_rxc     = w_nempty;
   assign o_dor     = r_dor;
   assign o_irq     = w_nempty & i_rxcie;
   assign o_level   = w_level;

endmodule

// File: tb/tb_usart_rx_buffer_ctrl.sv
// Directed bench for usart_rx_buffer_ctrl: queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_usart_rx_buffer_ctrl;
   localparam int DATA_W = 9;
   localparam int DEPTH  = 2;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       rxen = 0, frame_done = 0, parity_err = 0, frame_err = 0, rd_en = 0, rxcie = 1;
   logic [8:0] frame_data = '0;
   logic [2:0] ucsz = 3'd3;
   logic [8:0] rx_data;
   logic       rxc, fe, upe, dor, irq;
   logic [1:0] level;

   int n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   usart_rx_buffer_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_rxen(rxen), .i_frame_done(frame_done),
      .i_frame_data(frame_data), .i_parity_err(parity_err), .i_frame_err(frame_err),
      .i_ucsz(ucsz), .i_rd_en(rd_en), .i_rxcie(rxcie),
      .o_rx_data(rx_data), .o_rxc(rxc), .o_fe(fe), .o_upe(upe), .o_dor(dor),
      .o_irq(irq), .o_level(level)
   );

   // Reference model: queue of received entries plus a receiver mode
   typedef struct { logic [8:0] d; logic fe; logic pe; } ent_t;
   ent_t m_q[$];
   logic m_dor;
   int   m_mode; // 0 off, 1 receiving, 2 draining

   function automatic int nbits(input logic [2:0] u);
      case (u)
         3'd0: return 5;
         3'd1: return 6;
         3'd2: return 7;
         3'd7: return 9;
         default: return 8;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete(); m_dor = 0; m_mode = 0;
      end else begin
         int   lvl;
         bit   popped;
         ent_t e;
         lvl = m_q.size();
         popped = 0;
         if (lvl > 0 && (m_mode == 2 || rd_en)) begin
            void'(m_q.pop_front());
            popped = 1;
            if (rd_en) m_dor = 0;
         end
         if (m_mode == 1 && frame_done) begin
            if (lvl < DEPTH || popped) begin
               e.d  = frame_data & 9'((1 << nbits(ucsz)) - 1);
               e.fe = frame_err; e.pe = parity_err;
               m_q.push_back(e);
            end else m_dor = 1;
         end
         if (m_mode == 0) m_mode = rxen ? 1 : 0;
         else if (m_mode == 1) begin
            if (!rxen) begin
               if (lvl > 0) begin m_mode = 2; m_dor = 0; end
               else m_mode = 0;
            end
         end else if (lvl == 0) m_mode = rxen ? 1 : 0;
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(posedge clk) begin
      #2;
      if (rst_n) begin
         logic       e_rxc;
         logic [8:0] e_d;
         logic       e_fe, e_pe;
         e_rxc = (m_q.size() > 0);
         e_d   = e_rxc ? m_q[0].d  : 9'h0;
         e_fe  = e_rxc ? m_q[0].fe : 1'b0;
         e_pe  = e_rxc ? m_q[0].pe : 1'b0;
         chk("m_rxc",   16'(rxc),     16'(e_rxc));
         chk("m_data",  16'(rx_data), 16'(e_d));
         chk("m_fe",    16'(fe),      16'(e_fe));
         chk("m_upe",   16'(upe),     16'(e_pe));
         chk("m_dor",   16'(dor),     16'(m_dor));
         chk("m_irq",   16'(irq),     16'(e_rxc & rxcie));
         chk("m_level", 16'(level),   16'(m_q.size()));
      end
   end

   // One cycle: drive at negedge, single-cycle strobes cleared after the posedge
   task automatic step(input logic fd, input logic [8:0] d, input logic pe, input logic fr, input logic rd);
      @(negedge clk);
      frame_done = fd; frame_data = d; parity_err = pe; frame_err = fr; rd_en = rd;
      @(posedge clk);
      #1;
      frame_done = 0; rd_en = 0; parity_err = 0; frame_err = 0;
   endtask

   task automatic frame(input logic [8:0] d);
      step(1, d, 0, 0, 0);
   endtask

   task automatic rd();
      step(0, 9'h0, 0, 0, 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 9'h0, 0, 0, 0);
   endtask

   initial begin
      #12;
      chk("rst_rxc", 16'(rxc), 16'h0);
      chk("rst_level", 16'(level), 16'h0);
      chk("rst_dor", 16'(dor), 16'h0);
      chk("rst_irq", 16'(irq), 16'h0);
      @(negedge clk); rst_n = 1;

      // 1: single 8-bit frame, then read it
      rxen = 1; ucsz = 3'd3;
      idle(1);
      frame(9'h1A5);
      #2;
      chk("t1_rxc", 16'(rxc), 16'h1);
      chk("t1_data", 16'(rx_data), 16'h0A5);
      chk("t1_flags", 16'({fe, upe}), 16'h0);
      chk("t1_irq", 16'(irq), 16'h1);
      rd();
      #2 chk("t1_empty", 16'(rxc), 16'h0);

      // 2: overrun on third frame
      frame(9'h11); frame(9'h22); frame(9'h33);
      #2;
      chk("t2_level", 16'(level), 16'h2);
      chk("t2_dor", 16'(dor), 16'h1);
      chk("t2_head", 16'(rx_data), 16'h11);
      rd();
      #2;
      chk("t2_rd1", 16'(rx_data), 16'h22);
      chk("t2_dorclr", 16'(dor), 16'h0);
      rd();
      #2 chk("t2_empty", 16'(level), 16'h0);

      // 3: frame and read on a full buffer in the same cycle
      frame(9'h44); frame(9'h55);
      step(1, 9'h66, 0, 0, 1);
      #2;
      chk("t3_dor", 16'(dor), 16'h0);
      chk("t3_level", 16'(level), 16'h2);
      chk("t3_head", 16'(rx_data), 16'h55);
      rd();
      #2 chk("t3_next", 16'(rx_data), 16'h66);
      rd();

      // 4: 5-bit frame with both error flags
      ucsz = 3'd0;
      step(1, 9'h1FF, 1, 1, 0);
      #2;
      chk("t4_data", 16'(rx_data), 16'h01F);
      chk("t4_fe", 16'(fe), 16'h1);
      chk("t4_upe", 16'(upe), 16'h1);
      rd();
      ucsz = 3'd7;
      frame(9'h1C3);
      #2 chk("t4_9bit", 16'(rx_data), 16'h1C3);
      rd();

      // 5: flush on disable, frame during flush ignored
      ucsz = 3'd3;
      frame(9'h77); frame(9'h88);
      @(negedge clk); rxen = 0;
      idle(1);
      frame(9'h99);
      idle(1);
      #2;
      chk("t5_level", 16'(level), 16'h0);
      chk("t5_rxc", 16'(rxc), 16'h0);
      idle(2);
      chk("t5_dor", 16'(dor), 16'h0);

      // 6: async reset in the middle of a flush
      @(negedge clk); rxen = 1;
      idle(1);
      frame(9'h12); frame(9'h34); frame(9'h56);
      @(negedge clk); rxen = 0;
      idle(2);
      #1 rst_n = 0;
      #1;
      chk("t6_rxc", 16'(rxc), 16'h0);
      chk("t6_irq", 16'(irq), 16'h0);
      chk("t6_data", 16'(rx_data), 16'h0);
      chk("t6_level", 16'(level), 16'h0);
      chk("t6_dor", 16'(dor), 16'h0);
      @(negedge clk); rst_n = 1; rxen = 1;
      rd();
      #2;
      chk("t6_rdempty", 16'(level), 16'h0);
      chk("t6_rdrxc", 16'(rxc), 16'h0);
      idle(1);
      frame(9'h0AB);
      rd();
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
